// File: rtl/vram_pkg.sv
// Shared types and widths for the HPS-to-VRAM write path.
package vram_pkg;

    localparam int VRAM_ADDR_W = 13;
    localparam int VRAM_DATA_W = 64;
    localparam int VRAM_BE_W   = 8;

    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] addr;
        logic [VRAM_DATA_W-1:0] data;
        logic [VRAM_BE_W-1:0]   byteena;
    } vram_wr_t;

    typedef enum logic [1:0] {
        HOLD,
        DRAIN,
        VB_IDLE
    } sched_state_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Single-clock FIFO of VRAM write records; push/pop are pre-qualified by the caller.
module vram_wr_fifo
    import vram_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  vram_wr_t         wr_data,
    output vram_wr_t         rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    vram_wr_t         mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/vram_write_scheduler.sv
// Buffers HPS VRAM writes and releases them only during vertical blank,
// with a registered VRAM write port and sticky overflow/late flags.
module vram_write_scheduler
    import vram_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   h2f_wren,
    input  logic [VRAM_ADDR_W-1:0] h2f_wraddr,
    input  logic [VRAM_DATA_W-1:0] h2f_wrdata,
    input  logic [VRAM_BE_W-1:0]   h2f_byteena,
    input  logic                   vblank,
    input  logic                   err_clr,
    output logic                   vram_wren,
    output logic [VRAM_ADDR_W-1:0] vram_wraddr,
    output logic [VRAM_DATA_W-1:0] vram_wrdata,
    output logic [VRAM_BE_W-1:0]   vram_byteena,
    output logic [CNT_W-1:0]       pending,
    output logic                   overflow,
    output logic                   late,
    output logic                   drain_done
);

    sched_state_t     state_q, state_d;
    vram_wr_t         wr_q, wr_d;
    logic             wren_q, wren_d;
    logic             overflow_q, overflow_d;
    logic             late_q, late_d;
    logic             drain_done_q, drain_done_d;

    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    vram_wr_t         fifo_rd, fifo_wr;
    logic             pop_en, push_en, drop, drained;

    assign fifo_wr = '{addr: h2f_wraddr, data: h2f_wrdata, byteena: h2f_byteena};

    // A full FIFO still accepts a push when the same cycle pops.
    assign pop_en  = (state_q == DRAIN) && !fifo_empty;
    assign push_en = h2f_wren && (!fifo_full || pop_en);
    assign drop    = h2f_wren && fifo_full && !pop_en;
    assign drained = (fifo_empty || (pop_en && fifo_count == CNT_W'(1))) && !push_en;

    vram_wr_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_en),
        .pop     (pop_en),
        .wr_data (fifo_wr),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        drain_done_d = 1'b0;
        late_d       = late_q && !err_clr;
        overflow_d   = (overflow_q && !err_clr) || drop;
        wren_d       = pop_en;
        wr_d         = pop_en ? fifo_rd : wr_q;

        unique case (state_q)
            HOLD: begin
                if (vblank) begin
                    state_d = fifo_empty ? VB_IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (!vblank) begin
                    state_d = HOLD;
                    if (!fifo_empty) begin
                        late_d = 1'b1;
                    end
                end else if (drained) begin
                    state_d      = VB_IDLE;
                    drain_done_d = 1'b1;
                end
            end
            VB_IDLE: begin
                if (!vblank) begin
                    state_d = HOLD;
                end else if (h2f_wren || !fifo_empty) begin
                    state_d = DRAIN;
                end
            end
            default: state_d = HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HOLD;
            wr_q         <= '0;
            wren_q       <= 1'b0;
            overflow_q   <= 1'b0;
            late_q       <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            wren_q       <= wren_d;
            overflow_q   <= overflow_d;
            late_q       <= late_d;
            drain_done_q <= drain_done_d;
        end
    end

    assign vram_wren    = wren_q;
    assign vram_wraddr  = wr_q.addr;
    assign vram_wrdata  = wr_q.data;
    assign vram_byteena = wr_q.byteena;
    assign pending      = fifo_count;
    assign overflow     = overflow_q;
    assign late         = late_q;
    assign drain_done   = drain_done_q;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed bench for vram_write_scheduler: a cycle table plus hand-written corner sequences.
module tb_vram_write_scheduler;
    import vram_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        h2f_wren;
    logic [12:0] h2f_wraddr;
    logic [63:0] h2f_wrdata;
    logic [7:0]  h2f_byteena;
    logic        vblank;
    logic        err_clr;
    logic        vram_wren;
    logic [12:0] vram_wraddr;
    logic [63:0] vram_wrdata;
    logic [7:0]  vram_byteena;
    logic [4:0]  pending;
    logic        overflow;
    logic        late;
    logic        drain_done;

    int n_tests = 0;
    int n_fail  = 0;
    vram_wr_t wr_log[$];

    vram_write_scheduler #(.DEPTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .h2f_wren     (h2f_wren),
        .h2f_wraddr   (h2f_wraddr),
        .h2f_wrdata   (h2f_wrdata),
        .h2f_byteena  (h2f_byteena),
        .vblank       (vblank),
        .err_clr      (err_clr),
        .vram_wren    (vram_wren),
        .vram_wraddr  (vram_wraddr),
        .vram_wrdata  (vram_wrdata),
        .vram_byteena (vram_byteena),
        .pending      (pending),
        .overflow     (overflow),
        .late         (late),
        .drain_done   (drain_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (vram_wren) wr_log.push_back('{addr: vram_wraddr, data: vram_wrdata, byteena: vram_byteena});
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wren;
        logic [12:0] addr;
        logic        vb;
        logic        e_wren;
        logic [12:0] e_addr;
        logic [63:0] e_data;
        logic [7:0]  e_be;
        logic [4:0]  e_pend;
        logic        e_dd;
    } vec_t;

    function automatic logic [63:0] mk_data(input logic [12:0] a);
        return 64'hC0DE_0000_0000_0000 | {51'b0, a};
    endfunction

    function automatic vec_t mkv(input logic wren, input logic [12:0] addr, input logic vb,
                                 input logic e_wren, input logic [12:0] e_addr, input logic [63:0] e_data,
                                 input logic [7:0] e_be, input logic [4:0] e_pend, input logic e_dd);
        vec_t v;
        v.wren = wren; v.addr = addr; v.vb = vb;
        v.e_wren = e_wren; v.e_addr = e_addr; v.e_data = e_data;
        v.e_be = e_be; v.e_pend = e_pend; v.e_dd = e_dd;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic push_burst(input logic [12:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            h2f_wren    = 1'b1;
            h2f_wraddr  = base + 13'(i);
            h2f_wrdata  = mk_data(base + 13'(i));
            h2f_byteena = 8'hFF;
            step();
        end
        h2f_wren = 1'b0;
    endtask

    task automatic check_log(input string name, input logic [12:0] base, input int n);
        check($sformatf("%s_count", name), 128'(wr_log.size()), 128'(n));
        for (int i = 0; i < n && i < wr_log.size(); i++) begin
            check($sformatf("%s_entry%0d", name, i),
                  {51'b0, wr_log[i].addr, wr_log[i].data},
                  {51'b0, base + 13'(i), mk_data(base + 13'(i))});
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {34'b0, vram_wren, vram_wraddr, vram_wrdata, vram_byteena, pending, overflow, late, drain_done};
    endfunction

    vec_t tbl[10];

    initial begin
        int n_wr;

        rst = 1'b1; h2f_wren = 1'b0; h2f_wraddr = '0; h2f_wrdata = '0; h2f_byteena = '0;
        vblank = 1'b0; err_clr = 1'b0;

        tbl[0] = mkv(1, 13'h010, 0, 0, 13'h000, 64'h0, 8'h00, 5'd1, 0);
        tbl[1] = mkv(1, 13'h011, 0, 0, 13'h000, 64'h0, 8'h00, 5'd2, 0);
        tbl[2] = mkv(1, 13'h012, 0, 0, 13'h000, 64'h0, 8'h00, 5'd3, 0);
        tbl[3] = mkv(0, 13'h000, 0, 0, 13'h000, 64'h0, 8'h00, 5'd3, 0);
        tbl[4] = mkv(0, 13'h000, 1, 0, 13'h000, 64'h0, 8'h00, 5'd3, 0);
        tbl[5] = mkv(0, 13'h000, 1, 1, 13'h010, mk_data(13'h010), 8'hFF, 5'd2, 0);
        tbl[6] = mkv(0, 13'h000, 1, 1, 13'h011, mk_data(13'h011), 8'hFF, 5'd1, 0);
        tbl[7] = mkv(0, 13'h000, 1, 1, 13'h012, mk_data(13'h012), 8'hFF, 5'd0, 1);
        tbl[8] = mkv(0, 13'h000, 1, 0, 13'h012, mk_data(13'h012), 8'hFF, 5'd0, 0);
        tbl[9] = mkv(0, 13'h000, 0, 0, 13'h012, mk_data(13'h012), 8'hFF, 5'd0, 0);

        #1;
        check("reset_outputs", all_outs(), 128'h0);
        run(2);
        rst = 1'b0;
        step();

        // Hold then drain, cycle by cycle.
        for (int i = 0; i < 10; i++) begin
            h2f_wren    = tbl[i].wren;
            h2f_wraddr  = tbl[i].addr;
            h2f_wrdata  = mk_data(tbl[i].addr);
            h2f_byteena = 8'hFF;
            vblank      = tbl[i].vb;
            step();
            check($sformatf("table_row%0d", i), all_outs(),
                  {34'b0, tbl[i].e_wren, tbl[i].e_addr, tbl[i].e_data, tbl[i].e_be,
                   tbl[i].e_pend, 1'b0, 1'b0, tbl[i].e_dd});
        end
        h2f_wren = 1'b0;

        // Late push while idling in vblank.
        vblank = 1'b1;
        step();
        h2f_wren = 1'b1; h2f_wraddr = 13'h1ABC; h2f_wrdata = 64'hDEADBEEF_01234567; h2f_byteena = 8'h0F;
        step();
        h2f_wren = 1'b0;
        check("reentry_no_bypass", 128'(vram_wren), 128'(0));
        step();
        check("reentry_write", {42'b0, vram_wren, vram_wraddr, vram_wrdata, vram_byteena},
              {42'b0, 1'b1, 13'h1ABC, 64'hDEADBEEF_01234567, 8'h0F});
        check("reentry_drain_done", 128'(drain_done), 128'(1));
        step();
        check("reentry_after", {126'b0, vram_wren, drain_done}, 128'h0);
        vblank = 1'b0;
        step();

        // Overflow: 18 pushes into 16 entries.
        push_burst(13'h100, 18);
        check("ovf_pending", 128'(pending), 128'(16));
        check("ovf_flag", 128'(overflow), 128'(1));
        wr_log.delete();
        vblank = 1'b1;
        run(20);
        vblank = 1'b0;
        step();
        check_log("ovf_drain", 13'h100, 16);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("ovf_cleared", {126'b0, overflow, late}, 128'h0);

        // Late: vblank too short to drain 10 entries.
        wr_log.delete();
        push_burst(13'h200, 10);
        vblank = 1'b1;
        run(4);
        vblank = 1'b0;
        run(2);
        check("late_writes_le5", 128'(wr_log.size() <= 5), 128'(1));
        check("late_pending", 128'(pending), 128'(6));
        check("late_flag", 128'(late), 128'(1));
        vblank = 1'b1;
        run(12);
        vblank = 1'b0;
        step();
        check_log("late_all", 13'h200, 10);
        check("late_drained", {123'b0, pending}, 128'h0);
        check("late_sticky", 128'(late), 128'(1));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("late_cleared", 128'(late), 128'(0));

        // Full FIFO with push and pop every cycle.
        wr_log.delete();
        push_burst(13'h300, 16);
        check("full_pending", {123'b0, pending}, 128'(16));
        vblank = 1'b1;
        step();
        for (int j = 0; j < 8; j++) begin
            h2f_wren    = 1'b1;
            h2f_wraddr  = 13'h310 + 13'(j);
            h2f_wrdata  = mk_data(13'h310 + 13'(j));
            h2f_byteena = 8'hFF;
            step();
            check($sformatf("full_pushpop%0d", j), {122'b0, pending, overflow}, {122'b0, 5'd16, 1'b0});
        end
        h2f_wren = 1'b0;
        run(20);
        vblank = 1'b0;
        step();
        check_log("full_order", 13'h300, 24);

        // err_clr coinciding with a drop: set wins.
        push_burst(13'h500, 16);
        h2f_wren = 1'b1; err_clr = 1'b1;
        step();
        h2f_wren = 1'b0;
        check("clr_vs_set", 128'(overflow), 128'(1));
        step();
        err_clr = 1'b0;
        check("clr_alone", 128'(overflow), 128'(0));

        // Reset mid-drain.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        push_burst(13'h600, 5);
        vblank = 1'b1;
        n_wr = 0;
        for (int k = 0; k < 20 && n_wr < 2; k++) begin
            step();
            if (vram_wren) n_wr++;
        end
        check("rst_two_writes_seen", 128'(n_wr), 128'(2));
        #2 rst = 1'b1;
        vblank = 1'b0;
        #1;
        check("rst_outputs_zero", all_outs(), 128'h0);
        #10 rst = 1'b0;
        wr_log.delete();
        step();
        check("rst_state_hold", 128'(dut.state_q), 128'(HOLD));
        check("rst_pending_zero", {123'b0, pending}, 128'h0);
        vblank = 1'b1;
        run(10);
        vblank = 1'b0;
        step();
        check("rst_no_more_writes", 128'(wr_log.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_write_scheduler.md
Name: vram_write_scheduler

Overview:
- Sits between the HPS-to-FPGA VRAM write export (13-bit word address, 64-bit data, 8-bit byte enable, write strobe) and the VRAM write port.
- Buffers HPS writes and releases them to VRAM only while the PPU reports vertical blank, so CPU updates never tear the visible frame.
- Reports FIFO occupancy and two sticky error flags: dropped writes, and writes left pending at vblank end.

Parameters:
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1: width of pending count.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- h2f_wren  in  1  HPS write strobe; one write per high cycle; no backpressure.
- h2f_wraddr  in  13  HPS write word address.
- h2f_wrdata  in  64  HPS write data.
- h2f_byteena  in  8  HPS byte enables.
- vblank  in  1  high during PPU vertical blank (same clock domain).
- err_clr  in  1  one-cycle pulse; clears both sticky error flags.
- vram_wren  out  1  VRAM write strobe.
- vram_wraddr  out  13  VRAM write address.
- vram_wrdata  out  64  VRAM write data.
- vram_byteena  out  8  VRAM byte enables.
- pending  out  CNT_W  current FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky: at least one HPS write was dropped.
- late  out  1  sticky: vblank fell while the FIFO was non-empty.
- drain_done  out  1  one-cycle pulse when the FIFO empties during vblank.

Behaviour:
- Interface decision: one clock (clk); reset rst is asynchronous and active-high.
- Reset:
  - All outputs are 0.
  - FIFO is flushed (pointers and count = 0).
  - FSM enters HOLD.
  - Reset asserted mid-drain discards all buffered writes; no partial VRAM write follows deassertion.
- Push:
  - When h2f_wren=1 and the FIFO is not full, {addr, data, byteena} is written at the tail.
  - When full, the write is dropped and overflow is set.
- Pop: pop_en = (state==DRAIN) and FIFO non-empty. One entry is popped per cycle.
- Output stage:
  - Outputs are registered.
  - The cycle after a pop: vram_wren=1, and addr/data/byteena equal the popped entry.
  - Otherwise vram_wren=0, and addr/data/byteena hold their last values.
- Latency: a write accepted at cycle t reaches VRAM no earlier than t+2. There is no FIFO bypass.
- Ordering: strict FIFO. No coalescing of writes to the same address.
- Simultaneous push and pop:
  - When full: both occur and the count is unchanged; no overflow.
  - When empty: the push is accepted and no pop occurs that cycle.
- pending: updated the cycle after push/pop. +1 on push only, -1 on pop only, unchanged on both or neither.
- FSM (3 states, evaluated each cycle on current inputs):
  - HOLD: vblank=0, no pops.
    - vblank=1 and non-empty -> DRAIN.
    - vblank=1 and empty -> VB_IDLE.
  - DRAIN: popping.
    - vblank=0 -> HOLD. If the FIFO is non-empty at that edge, set late.
    - FIFO becomes empty with vblank=1 -> VB_IDLE, with drain_done pulsed for one cycle.
  - VB_IDLE: vblank=1, empty.
    - A new push -> DRAIN on the next cycle, so late-arriving writes still drain within vblank.
    - vblank=0 -> HOLD.
- A pop already issued in the last vblank cycle still produces its VRAM write the following cycle, even though vblank is then low. The output register commits regardless of vblank.
- Sticky flags:
  - err_clr clears overflow and late.
  - If err_clr coincides with a new set event, set wins and the flag stays 1.
- drain_done fires only on the DRAIN->VB_IDLE transition, never from HOLD.

Decomposition:
- Package vram_pkg:
  - Constants VRAM_ADDR_W=13, VRAM_DATA_W=64, VRAM_BE_W=8.
  - Packed struct vram_wr_t {addr, data, byteena} (85 bits).
  - Enum sched_state_t {HOLD, DRAIN, VB_IDLE}.
- Sub-module vram_wr_fifo:
  - Synchronous single-clock FIFO of vram_wr_t, parameter DEPTH.
  - Outputs full, empty and count; async active-high reset.
- The top level holds the FSM, output register and sticky flags.

Test Plan:
- Reset mid-drain: push 5 writes, raise vblank, assert rst after 2 VRAM writes -> no further vram_wren; pending=0; all outputs 0; state HOLD after release.
- Hold then drain: push 3 writes (addr 0x010/0x011/0x012, byteena 0xFF) with vblank=0 -> no vram_wren. Raise vblank -> three consecutive vram_wren cycles in order, then a drain_done pulse with pending=0.
- Overflow: with vblank=0, push DEPTH+2=18 writes -> pending=16 and overflow=1. Drain yields exactly the first 16 addresses. err_clr -> overflow=0.
- Late: push 10 writes, hold vblank high for 4 cycles -> at most 5 VRAM writes (4 pops plus the registered output). The rest are retained with pending=6 and late=1. The next vblank drains the remaining 6.
- Full plus simultaneous push/pop: fill to 16, then push every cycle during vblank -> no overflow, pending stays 16, VRAM order matches push order.
- VB_IDLE re-entry: in vblank with an empty FIFO, push 1 write (addr 0x1ABC, data 0xDEADBEEF_01234567, byteena 0x0F) -> vram_wren 2 cycles later with exact fields, then a drain_done pulse.
